// File: rtl/sort_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : sort_unloader
//  Purpose  : Snapshots a parallel sorter's cells when a frame ends, pulses
//             clear_o to reset the sorter, then streams the captured entries
//             head-first over a valid/ready interface.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk             in   sole clock, rising edge
//    rst_n           in   synchronous active-low reset
//    cell_data_i     in   DEPTH*SORTB flattened keys, cell 0 = sort head
//    cell_metadata_i in   DEPTH*METAB flattened metadata, same indexing
//    frame_done_i    in   one-cycle end-of-frame pulse
//    count_i         in   entries pushed in the frame (sampled with frame_done_i)
//    data_o          out  streamed key
//    metadata_o      out  streamed metadata
//    valid_o         out  data_o/metadata_o valid
//    ready_i         in   downstream accept
//    last_o          out  final beat of the frame
//    clear_o         out  one-cycle sorter reset pulse
//    busy_o          out  draining
//    done_o          out  one-cycle end-of-readout pulse
//    ovf_o           out  count_i exceeded DEPTH for the current frame
//    drop_o          out  one-cycle pulse, frame_done_i discarded while busy
// ============================================================================
module sort_unloader #(
  parameter int DEPTH = 8,
  parameter int SORTB = 8,
  parameter int METAB = 32,
  parameter int CNTB  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DEPTH*SORTB-1:0]   cell_data_i,
  input  logic [DEPTH*METAB-1:0]   cell_metadata_i,
  input  logic                     frame_done_i,
  input  logic [CNTB-1:0]          count_i,
  output logic [SORTB-1:0]         data_o,
  output logic [METAB-1:0]         metadata_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic                     clear_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o,
  output logic                     drop_o
);

  // NB holds 0..DEPTH (entry count); AB addresses a shadow slot.
  localparam int NB   = $clog2(DEPTH + 1);
  localparam int AB   = $clog2(DEPTH);
  localparam int CNTW = CNTB + 1;
  localparam logic [CNTB:0] DEPTH_CNT = CNTW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SORTB-1:0]  key_q  [DEPTH];
  logic [SORTB-1:0]  key_d  [DEPTH];
  logic [METAB-1:0]  meta_q [DEPTH];
  logic [METAB-1:0]  meta_d [DEPTH];
  logic [NB-1:0]     n_q, n_d;
  logic [NB-1:0]     idx_q, idx_d;
  logic [SORTB-1:0]  data_q, data_d;
  logic [METAB-1:0]  metadata_q, metadata_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              drop_q, drop_d;

  logic              cap_ovf;
  logic [NB-1:0]     cap_n;
  logic [NB-1:0]     idx_nxt;

  // Saturated entry count for a capture in this cycle.
  assign cap_ovf = ({1'b0, count_i} > DEPTH_CNT);
  assign cap_n   = cap_ovf ? NB'(DEPTH) : count_i[NB-1:0];
  assign idx_nxt = idx_q + NB'(1);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    meta_d     = meta_q;
    n_d        = n_q;
    idx_d      = idx_q;
    data_d     = data_q;
    metadata_d = metadata_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    clear_d    = 1'b0;
    done_d     = 1'b0;
    drop_d     = 1'b0;

    if (state_q == IDLE) begin
      if (frame_done_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          key_d[k]  = cell_data_i[k*SORTB +: SORTB];
          meta_d[k] = cell_metadata_i[k*METAB +: METAB];
        end
        n_d     = cap_n;
        ovf_d   = cap_ovf;
        idx_d   = '0;
        clear_d = 1'b1;
        if (cap_n == '0) begin
          // Empty frame: nothing to stream, finish immediately.
          done_d = 1'b1;
        end else begin
          // Head is presented straight from the cells so the first beat
          // appears one cycle after frame_done_i.
          state_d    = DRAIN;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          data_d     = cell_data_i[0 +: SORTB];
          metadata_d = cell_metadata_i[0 +: METAB];
          last_d     = (cap_n == NB'(1));
        end
      end
    end else begin
      // A frame end while draining (including on the final transfer edge)
      // is discarded; the sorter is not cleared.
      if (frame_done_i) begin
        drop_d = 1'b1;
      end
      if (valid_q && ready_i) begin
        if (last_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_nxt;
          data_d     = key_q[idx_nxt[AB-1:0]];
          metadata_d = meta_q[idx_nxt[AB-1:0]];
          last_d     = (idx_nxt == n_q - NB'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        key_q[k]  <= '0;
        meta_q[k] <= '0;
      end
      n_q        <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      metadata_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      meta_q     <= meta_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      metadata_q <= metadata_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      clear_q    <= clear_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign data_o     = data_q;
  assign metadata_o = metadata_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign clear_o    = clear_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;
  assign drop_o     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_unloader
//  Purpose  : Self-checking bench for sort_unloader (DEPTH=4). A queue-based
//             frame model predicts outputs every cycle; directed scenarios
//             add literal expectations on beat order and pulse timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sort_unloader;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [D*8-1:0]  cell_data;
  logic [D*32-1:0] cell_meta;
  logic          frame_done;
  logic [15:0]   count;
  logic          ready;
  logic [7:0]    data_o;
  logic [31:0]   metadata_o;
  logic          valid_o, last_o, clear_o, busy_o, done_o, ovf_o, drop_o;

  sort_unloader #(.DEPTH(D), .SORTB(8), .METAB(32), .CNTB(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cell_data_i    (cell_data),
    .cell_metadata_i(cell_meta),
    .frame_done_i   (frame_done),
    .count_i        (count),
    .data_o         (data_o),
    .metadata_o     (metadata_o),
    .valid_o        (valid_o),
    .ready_i        (ready),
    .last_o         (last_o),
    .clear_o        (clear_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ovf_o          (ovf_o),
    .drop_o         (drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  key;
    logic [31:0] meta;
  } beat_t;

  beat_t mq[$];       // beats still owed to downstream, head first
  bit    m_busy, m_clear, m_done, m_drop, m_ovf;
  bit    started = 0;

  always @(posedge clk) begin
    bit was;
    int n;
    beat_t b;
    started = 1;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_clear = 0; m_done = 0; m_drop = 0; m_ovf = 0;
    end else begin
      was = m_busy;
      m_clear = 0; m_done = 0; m_drop = 0;
      if (was && ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (frame_done) begin
        if (was) m_drop = 1;
        else begin
          n = (count > 16'(D)) ? D : int'(count);
          m_ovf = (count > 16'(D));
          m_clear = 1;
          for (int k = 0; k < n; k++) begin
            b.key  = cell_data[k*8 +: 8];
            b.meta = cell_meta[k*32 +: 32];
            mq.push_back(b);
          end
          if (n == 0) m_done = 1;
          else m_busy = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int log_q[$];   // keys actually transferred

  always @(negedge clk) begin
    if (started) begin
      chk("valid_o", 64'(valid_o), 64'(m_busy));
      chk("busy_o",  64'(busy_o),  64'(m_busy));
      chk("clear_o", 64'(clear_o), 64'(m_clear));
      chk("done_o",  64'(done_o),  64'(m_done));
      chk("drop_o",  64'(drop_o),  64'(m_drop));
      chk("ovf_o",   64'(ovf_o),   64'(m_ovf));
      if (m_busy && mq.size() > 0) begin
        chk("data_o",     64'(data_o),     64'(mq[0].key));
        chk("metadata_o", 64'(metadata_o), 64'(mq[0].meta));
        chk("last_o",     64'(last_o),     64'(mq.size() == 1));
      end
      if (valid_o && ready) log_q.push_back(int'(data_o));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cells(input int k0, input int k1, input int k2, input int k3);
    int kk[4];
    kk[0] = k0; kk[1] = k1; kk[2] = k2; kk[3] = k3;
    for (int k = 0; k < D; k++) begin
      cell_data[k*8 +: 8]   = 8'(kk[k]);
      cell_meta[k*32 +: 32] = 32'hA000_0000 + 32'(kk[k] * 256 + k);
    end
  endtask

  // Issue a one-cycle frame_done; returns positioned in cycle t+1.
  task automatic frame(input int cnt);
    count = 16'(cnt);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic drain(input string nm);
    int c = 0;
    while (busy_o && c < 60) begin
      tick();
      c++;
    end
    if (c >= 60) chk({nm, "_drain_timeout"}, 64'(1), 64'(0));
    tick();
    tick();
  endtask

  task automatic chk_log(input string nm, input int n, input int e0, input int e1,
                         input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_beats"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < log_q.size()) chk({nm, "_beat"}, 64'(log_q[i]), 64'(e[i]));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int pat[4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    rst_n = 1'b0; frame_done = 1'b0; count = '0; ready = 1'b1;
    cell_data = '0; cell_meta = '0;
    // frame_done coincident with reset must be ignored
    set_cells(1, 2, 3, 4);
    repeat (2) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_clear", 64'(clear_o), 64'(0));
    chk("rst_busy",  64'(busy_o),  64'(0));
    chk("rst_data",  64'(data_o),  64'(0));
    chk("rst_meta",  64'(metadata_o), 64'(0));
    chk("rst_flags", 64'({last_o, done_o, ovf_o, drop_o}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Full frame, ready held high
    log_q.delete();
    set_cells(9, 7, 4, 2);
    frame(4);
    chk("t1_clear", 64'(clear_o), 64'(1));
    chk("t1_first", 64'(data_o), 64'(9));
    chk("t1_valid", 64'(valid_o), 64'(1));
    repeat (4) tick();
    chk("t1_done_t5", 64'(done_o), 64'(1));
    chk("t1_busy_t5", 64'(busy_o), 64'(0));
    tick();
    chk_log("t1", 4, 9, 7, 4, 2);

    // Partial frame
    log_q.delete();
    set_cells(9, 7, 0, 0);
    frame(2);
    drain("t2");
    chk_log("t2", 2, 9, 7, 0, 0);
    chk("t2_ovf", 64'(ovf_o), 64'(0));

    // Overflow then empty frame
    log_q.delete();
    set_cells(1, 2, 3, 4);
    frame(6);
    drain("t3");
    chk_log("t3", 4, 1, 2, 3, 4);
    chk("t3_ovf_hold", 64'(ovf_o), 64'(1));
    log_q.delete();
    frame(0);
    chk("t3_zero_done", 64'(done_o), 64'(1));
    chk("t3_zero_valid", 64'(valid_o), 64'(0));
    chk("t3_zero_ovf", 64'(ovf_o), 64'(0));
    drain("t3z");
    chk("t3_zero_beats", 64'(log_q.size()), 64'(0));

    // Back-pressure with cell changes mid-drain
    log_q.delete();
    set_cells(5, 6, 7, 8);
    ready = 1'b1;
    frame(4);
    for (int i = 0; i < 30 && busy_o; i++) begin
      ready = pat[i % 4][0];
      if (i == 2) set_cells(99, 98, 97, 96);
      tick();
    end
    ready = 1'b1;
    drain("t4");
    chk_log("t4", 4, 5, 6, 7, 8);

    // Frame end during beat 2 is dropped
    log_q.delete();
    set_cells(11, 12, 13, 14);
    frame(4);
    tick();
    set_cells(50, 51, 52, 53);
    frame(3);
    chk("t5_drop", 64'(drop_o), 64'(1));
    chk("t5_noclear", 64'(clear_o), 64'(0));
    drain("t5");
    chk_log("t5", 4, 11, 12, 13, 14);

    // Frame end on the final transfer edge is dropped
    log_q.delete();
    set_cells(40, 41, 42, 43);
    frame(1);
    chk("t6_last", 64'(last_o), 64'(1));
    frame(2);
    chk("t6_drop", 64'(drop_o), 64'(1));
    chk("t6_done", 64'(done_o), 64'(1));
    chk("t6_idle", 64'(valid_o), 64'(0));
    drain("t6");
    chk_log("t6", 1, 40, 0, 0, 0);

    // Reset at beat 2 aborts the frame
    log_q.delete();
    set_cells(21, 22, 23, 24);
    frame(4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_valid", 64'(valid_o), 64'(0));
    chk("t7_busy",  64'(busy_o),  64'(0));
    chk("t7_done",  64'(done_o),  64'(0));
    tick();
    chk("t7_nodone", 64'(done_o), 64'(0));
    log_q.delete();
    set_cells(31, 32, 33, 34);
    frame(4);
    drain("t7");
    chk_log("t7", 4, 31, 32, 33, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_unloader.md
SORT_UNLOADER -- requirements
Module: sort_unloader

Interface
REQ-001 Parameter DEPTH, default 8: number of sorter cells captured per frame; DEPTH SHALL be >= 2.
REQ-002 Parameter SORTB, default 8: sort-key width per cell.
REQ-003 Parameter METAB, default 32: metadata width per cell.
REQ-004 Parameter CNTB, default 16: width of the frame entry count.
REQ-005 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-006 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1: synchronous active-low reset.
REQ-008 Port cell_data_i, input, DEPTH*SORTB: flattened cell keys; cell k occupies bits [k*SORTB +: SORTB]; cell 0 is the sort head.
REQ-009 Port cell_metadata_i, input, DEPTH*METAB: flattened cell metadata, same indexing.
REQ-010 Port frame_done_i, input, 1: one-cycle pulse marking end of an input frame.
REQ-011 Port count_i, input, CNTB: number of entries pushed in the frame, sampled with frame_done_i.
REQ-012 Port data_o, output, SORTB: streamed key.
REQ-013 Port metadata_o, output, METAB: streamed metadata.
REQ-014 Port valid_o, output, 1: data_o/metadata_o valid.
REQ-015 Port ready_i, input, 1: downstream accept.
REQ-016 Port last_o, output, 1: current beat is the final beat of the frame.
REQ-017 Port clear_o, output, 1: one-cycle pulse that drives the sorter cells' reset.
REQ-018 Port busy_o, output, 1: unloader is draining.
REQ-019 Port done_o, output, 1: one-cycle pulse at end of frame readout.
REQ-020 Port ovf_o, output, 1: latched, count_i exceeded DEPTH for the current frame.
REQ-021 Port drop_o, output, 1: one-cycle pulse, frame_done_i arrived while busy and was discarded.

Function
REQ-022 FSM SHALL have exactly two states, IDLE and DRAIN.
REQ-023 IDLE, frame_done_i=1 at edge t: all DEPTH keys/metadata SHALL be copied into shadow registers; n SHALL latch min(count_i, DEPTH); ovf_o SHALL latch (count_i > DEPTH); clear_o SHALL be 1 in cycle t+1 only.
REQ-024 If latched n=0: state SHALL stay IDLE, done_o SHALL pulse in t+1, valid_o SHALL stay 0.
REQ-025 If n>0: state SHALL be DRAIN from t+1; busy_o=1 and valid_o=1 in t+1; read index idx=0.
REQ-026 In DRAIN, data_o/metadata_o SHALL equal shadow entry idx; last_o SHALL equal (idx == n-1).
REQ-027 Transfer occurs on a cycle with valid_o & ready_i; idx SHALL increment by 1 per transfer.
REQ-028 Without transfer, valid_o, data_o, metadata_o, last_o SHALL hold stable.
REQ-029 Transfer with last_o=1: next cycle state SHALL be IDLE, valid_o=0, busy_o=0, done_o=1 for one cycle.
REQ-030 frame_done_i in DRAIN SHALL not modify shadow, n, idx, or ovf_o; drop_o SHALL pulse the following cycle; clear_o SHALL not pulse.
REQ-031 frame_done_i on the same edge as the final transfer SHALL be treated as arriving in DRAIN (dropped).
REQ-032 Shadow contents SHALL be unaffected by cell_data_i changes after capture.
REQ-033 ovf_o SHALL hold until the next accepted frame_done_i.
REQ-034 Throughput SHALL be one beat per cycle with ready_i held 1; latency frame_done_i to first valid_o SHALL be exactly 1 cycle.

Reset
REQ-035 rst_n=0 SHALL force IDLE, idx=0, n=0, and valid_o, last_o, clear_o, busy_o, done_o, ovf_o, drop_o all 0; data_o/metadata_o SHALL be 0.
REQ-036 rst_n=0 during DRAIN SHALL abort the frame with no done_o pulse; shadow contents need not be cleared.
REQ-037 frame_done_i coincident with rst_n=0 SHALL be ignored.

Verification
REQ-038 DEPTH=4, keys {9,7,4,2}, count_i=4, ready_i=1 -> clear_o pulse t+1; beats 9,7,4,2 in t+1..t+4; last_o on 2; done_o at t+5.
REQ-039 count_i=2, keys {9,7,0,0} -> exactly two beats 9,7, last_o on 7, ovf_o=0.
REQ-040 count_i=6, DEPTH=4 -> four beats, ovf_o=1 until next frame; count_i=0 -> no valid_o, done_o at t+1.
REQ-041 ready_i toggling 1,0,0,1,... -> every key delivered once in order, outputs stable during stalls, cell_data_i changes mid-drain not visible.
REQ-042 frame_done_i during beat 2 -> drop_o pulse, no clear_o, original frame completes unchanged.
REQ-043 rst_n=0 at beat 2 -> next cycle valid_o=0, busy_o=0, no done_o; new frame afterwards drains normally.
